// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts single-cycle CPU bus requests into APB4 transfers
// to NUM_SLAVES peripherals, decoding the slave from busAddr[15:12].
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [15:0] PERIPH_BASE    = 16'h1000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       transfer,
  input  logic                       busWe,
  input  logic [31:0]                busAddr,
  input  logic [31:0]                busWData,
  input  logic [3:0]                 Byte_Enable,
  output logic                       ready,
  output logic [31:0]                busRData,
  output logic                       busErr,
  output logic [31:0]                PADDR,
  output logic                       PWRITE,
  output logic [31:0]                PWDATA,
  output logic [3:0]                 PSTRB,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state;
  logic                  mapped;
  logic [NUM_SLAVES-1:0] sel_dec;
  logic                  pready_sel;
  logic [31:0]           prdata_sel;
  logic                  done;
  logic                  timeout;

  assign mapped = (busAddr[31:16] == PERIPH_BASE) &&
                  ({1'b0, busAddr[15:12]} < 5'(NUM_SLAVES));

  // One-hot slave select decoded from the request address
  always_comb begin
    sel_dec = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (busAddr[15:12] == 4'(i)) sel_dec[i] = 1'b1;
    end
  end

  // Pick PREADY/PRDATA of the slave currently selected by the registered PSEL
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) begin
        pready_sel = PREADY[i];
        prdata_sel = PRDATA[32*i +: 32];
      end
    end
  end

  assign done = (state == ACCESS) && pready_sel;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  assign timeout = (state == ACCESS) && !pready_sel && (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // CPU-side response; forced quiet while reset is held
  always_comb begin
    ready    = 1'b0;
    busErr   = 1'b0;
    busRData = '0;
    if (!reset) begin
      if ((state == IDLE) && transfer && !mapped) begin
        ready  = 1'b1;
        busErr = 1'b1;
      end else if (done) begin
        ready = 1'b1;
        if (!PWRITE) busRData = prdata_sel;
      end else if (timeout) begin
        ready    = 1'b1;
        busErr   = 1'b1;
        busRData = 32'hDEAD_BEEF;
      end
    end
  end

  // APB sequencer: IDLE -> SETUP -> ACCESS -> IDLE with registered APB outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
`ifdef APB_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (transfer && mapped) begin
            PADDR  <= busAddr;
            PWRITE <= busWe;
            PWDATA <= busWData;
            PSTRB  <= busWe ? Byte_Enable : 4'b0000;
            PSEL   <= sel_dec;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (done || timeout) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed checks of the APB master bridge.
module tb_apb_master_bridge;
  localparam int unsigned NS = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               transfer;
  logic               busWe;
  logic [31:0]        busAddr;
  logic [31:0]        busWData;
  logic [3:0]         Byte_Enable;
  logic               ready;
  logic [31:0]        busRData;
  logic               busErr;
  logic [31:0]        PADDR;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [3:0]         PSTRB;
  logic [NS-1:0]      PSEL;
  logic               PENABLE;
  logic [32*NS-1:0]   PRDATA;
  logic [NS-1:0]      PREADY;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_bridge #(
    .NUM_SLAVES(NS), .PERIPH_BASE(16'h1000), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .busWe(busWe),
    .busAddr(busAddr), .busWData(busWData), .Byte_Enable(Byte_Enable),
    .ready(ready), .busRData(busRData), .busErr(busErr),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; transfer = 1'b1; busWe = 1'b0; busAddr = 32'h2000_0000;
    busWData = '0; Byte_Enable = '0; PREADY = '1;
    PRDATA = {32'hCAFE_F00D, 32'h1234_5678, 32'h1111_1111, 32'h0000_00A0};
    tick(); tick();
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PSTRB} !== 10'b0) begin
      n_err++; $display("FAIL rst_ctrl: got psel=%b en=%b wr=%b strb=%b want all 0", PSEL, PENABLE, PWRITE, PSTRB);
    end
    n_cmp++;
    if ({PADDR, PWDATA} !== 64'h0) begin
      n_err++; $display("FAIL rst_bus: got paddr=%h pwdata=%h want 0", PADDR, PWDATA);
    end
    n_cmp++;
    if ({ready, busErr, busRData} !== 34'h0) begin
      n_err++; $display("FAIL rst_resp: got ready=%b err=%b rdata=%h want 0", ready, busErr, busRData);
    end
    reset = 1'b0; transfer = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    transfer = 1'b1; busWe = 1'b1; busAddr = 32'h1000_1004;
    busWData = 32'hA5A5_0001; Byte_Enable = 4'b0011; PREADY = '1;
    #1;
    n_cmp++;
    if ({ready, PSEL} !== 5'b0) begin
      n_err++; $display("FAIL wr_n: got ready=%b psel=%b want 0/0000", ready, PSEL);
    end
    tick();
    transfer = 1'b0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, PSTRB, PWRITE, ready} !== {4'b0010, 1'b0, 4'b0011, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL wr_setup: got psel=%b en=%b strb=%b wr=%b ready=%b want 0010/0/0011/1/0", PSEL, PENABLE, PSTRB, PWRITE, ready);
    end
    n_cmp++;
    if ({PADDR, PWDATA} !== {32'h1000_1004, 32'hA5A5_0001}) begin
      n_err++; $display("FAIL wr_bus: got paddr=%h pwdata=%h want 10001004/a5a50001", PADDR, PWDATA);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, ready, busErr, busRData} !== {4'b0010, 1'b1, 1'b1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL wr_access: got psel=%b en=%b ready=%b err=%b rdata=%h want 0010/1/1/0/0", PSEL, PENABLE, ready, busErr, busRData);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, ready} !== 6'b0) begin
      n_err++; $display("FAIL wr_idle: got psel=%b en=%b ready=%b want 0", PSEL, PENABLE, ready);
    end
  endtask

  task automatic test_read_wait();
    transfer = 1'b1; busWe = 1'b0; busAddr = 32'h1000_2008; Byte_Enable = 4'b1111;
    PREADY = 4'b0000;
    tick();
    transfer = 1'b0;
    #1;
    n_cmp++;
    if ({PSEL, PENABLE, PSTRB, PWRITE} !== {4'b0100, 1'b0, 4'b0000, 1'b0}) begin
      n_err++; $display("FAIL rd_setup: got psel=%b en=%b strb=%b wr=%b want 0100/0/0000/0", PSEL, PENABLE, PSTRB, PWRITE);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 5) PREADY = 4'b0100;
      #1;
      n_cmp++;
      if ({PADDR, PSEL, PENABLE, ready} !== {32'h1000_2008, 4'b0100, 1'b1, (k == 5)}) begin
        n_err++; $display("FAIL rd_cycle%0d: got paddr=%h psel=%b en=%b ready=%b want 10002008/0100/1/%0d", k, PADDR, PSEL, PENABLE, ready, (k == 5));
      end
    end
    n_cmp++;
    if ({busRData, busErr} !== {32'h1234_5678, 1'b0}) begin
      n_err++; $display("FAIL rd_data: got rdata=%h err=%b want 12345678/0", busRData, busErr);
    end
    tick();
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs[0] = 32'h2000_0000;
    addrs[1] = 32'h1000_5000;
    PREADY = '1;
    for (int k = 0; k < 2; k++) begin
      transfer = 1'b1; busWe = 1'b0; busAddr = addrs[k];
      #1;
      n_cmp++;
      if ({ready, busErr, busRData, PSEL} !== {1'b1, 1'b1, 32'h0, 4'b0}) begin
        n_err++; $display("FAIL unmapped%0d: got ready=%b err=%b rdata=%h psel=%b want 1/1/0/0000", k, ready, busErr, busRData, PSEL);
      end
      tick();
      n_cmp++;
      if ({PSEL, PENABLE} !== 5'b0) begin
        n_err++; $display("FAIL unmapped%0d_next: got psel=%b en=%b want 0", k, PSEL, PENABLE);
      end
    end
    transfer = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    transfer = 1'b1; busWe = 1'b1; busAddr = 32'h1000_1000; busWData = 32'h5555_AAAA;
    Byte_Enable = 4'b1111; PREADY = 4'b0000;
    tick();
    transfer = 1'b0;
    tick();
    reset = 1'b1; PREADY = 4'b0010;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++; $display("FAIL rstmid_ready: got %b want 0", ready);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA} !== 74'h0) begin
      n_err++; $display("FAIL rstmid_apb: got psel=%b en=%b wr=%b strb=%b paddr=%h pwdata=%h want 0", PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++; $display("FAIL rstmid_noready: got %b want 0", ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    transfer = 1'b1; busWe = 1'b1; busAddr = 32'h1000_0010; busWData = 32'h0BAD_CAFE;
    Byte_Enable = 4'b1000; PREADY = '1;
    tick();
    #1;
    n_cmp++;
    if (PSEL !== 4'b0001) begin
      n_err++; $display("FAIL b2b_sel1: got %b want 0001", PSEL);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready1: got %b want 1", ready);
    end
    busWe = 1'b0; busAddr = 32'h1000_300C;
    tick();
    n_cmp++;
    if ({PSEL, ready} !== 5'b0) begin
      n_err++; $display("FAIL b2b_gap: got psel=%b ready=%b want 0000/0", PSEL, ready);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PSTRB} !== {4'b1000, 1'b0, 1'b0, 32'h1000_300C, 4'b0000}) begin
      n_err++; $display("FAIL b2b_setup2: got psel=%b en=%b wr=%b paddr=%h strb=%b want 1000/0/0/1000300c/0000", PSEL, PENABLE, PWRITE, PADDR, PSTRB);
    end
    tick();
    transfer = 1'b0;
    #1;
    n_cmp++;
    if ({ready, busErr, busRData} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL b2b_read2: got ready=%b err=%b rdata=%h want 1/0/cafef00d", ready, busErr, busRData);
    end
    tick();
  endtask

  task automatic test_stuck_slave();
    transfer = 1'b1; busWe = 1'b0; busAddr = 32'h1000_1000; PREADY = 4'b0000;
    tick();
    transfer = 1'b0;
`ifdef APB_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_cmp++;
      if (ready !== 1'b0) begin
        n_err++; $display("FAIL to_wait%0d: got ready=%b want 0", k, ready);
      end
      tick();
    end
    n_cmp++;
    if ({ready, busErr, busRData} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL to_fire: got ready=%b err=%b rdata=%h want 1/1/deadbeef", ready, busErr, busRData);
    end
    tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 5'b0) begin
      n_err++; $display("FAIL to_drop: got psel=%b en=%b want 0", PSEL, PENABLE);
    end
`else
    for (int k = 1; k <= 10; k++) begin
      #1;
      n_cmp++;
      if ({ready, busErr} !== 2'b00) begin
        n_err++; $display("FAIL stuck%0d: got ready=%b err=%b want 0/0", k, ready, busErr);
      end
      tick();
    end
    PREADY = 4'b0010;
    #1;
    n_cmp++;
    if ({ready, busErr, busRData} !== {1'b1, 1'b0, 32'h1111_1111}) begin
      n_err++; $display("FAIL stuck_release: got ready=%b err=%b rdata=%h want 1/0/11111111", ready, busErr, busRData);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_unmapped();
    test_reset_mid_access();
    test_back_to_back();
    test_stuck_slave();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
